seven_segment_scan_decoder: RTL
===============================

Name: seven_segment_scan_decoder

Overview:
Receive-side counterpart of the team's binary-to-7-segment display driver. It monitors a time-multiplexed 7-segment bus (segment lines plus one-hot digit strobes) and recovers the binary value of each digit into registers. A stability filter rejects scan transients, and a frame pulse reports when every digit has been refreshed. Used for display loop-back checking and for reading panels driven by external controllers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1)
STABLE_CYCLES, 4, consecutive identical samples required before capture (>=1)
CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
seg_input  input  7  segment lines, active-high, bit0=a .. bit6=g; synchronous to clk
dig_sel  input  NUM_DIGITS  digit strobe, active-high, one-hot expected; bit i selects digit i
bin_output  output  4*NUM_DIGITS  recovered digits, nibble i = digit i
digit_valid  output  NUM_DIGITS  bit i = nibble i holds a legal decoded value
frame_valid  output  1  one-cycle pulse when all digits have been captured since the last pulse or reset
err_pulse  output  1  one-cycle pulse on an illegal pattern or a non-one-hot strobe

Behaviour:
- One clock. Reset is asynchronous and active-low, named rst_n, clocking on clk.
- Reset values: bin_output is 4'hF in every nibble; digit_valid, frame_valid, err_pulse, sample register, counter and seen-mask are all 0. Asserting rst_n mid-frame discards all state immediately. Capture restarts cleanly after release.
- Sample register s_reg holds {seg_input, dig_sel}:
  - On every edge where the inputs differ from s_reg: load s_reg and clear cnt.
  - Otherwise cnt increments and saturates at STABLE_CYCLES.
- Capture fires on an edge where the inputs equal s_reg and cnt == STABLE_CYCLES-1. Exactly one capture occurs per stable window.
- Latency: inputs held constant for STABLE_CYCLES+1 consecutive edges update the outputs on edge STABLE_CYCLES+1. Any change before that restarts the window with no update.
- Decode table (segment pattern to value) matches the display encoding exactly:
  - 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4
  - 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9
  - Every other pattern, including all-off, is illegal.
- On capture, if dig_sel is one-hot at bit i:
  - Legal pattern: nibble i <= value, digit_valid[i] <= 1.
  - Illegal pattern: nibble i <= 4'hF, digit_valid[i] <= 0, err_pulse = 1 for one cycle.
  - In both cases seen[i] <= 1.
- On capture with dig_sel == 0 (blanking interval): no output or mask change, no error.
- On capture with more than one dig_sel bit set: err_pulse for one cycle; no nibble, valid or mask change.
- Frame completion: when a capture makes seen all-ones, frame_valid pulses on that same edge and seen clears to 0. A re-capture of an already-seen digit does not advance the frame.
- err_pulse and frame_valid may assert on the same edge, since an illegal final digit still completes the frame.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package seven_seg_pkg holds the constants SEG_0..SEG_9 (7-bit patterns) and BLANK_NIBBLE = 4'hF.
- The display driver migrates to the same constants, so encode and decode cannot diverge.
- One natural sub-module, seven_segment_pattern_decode: combinational, 7-bit pattern in, {legal, 4-bit value} out.
- The scan/filter/frame logic stays in the top module.

Test Plan:
1. Reset check, with NUM_DIGITS=4 and STABLE_CYCLES=4: assert rst_n=0 asynchronously mid-cycle. Outputs go immediately to bin_output=16'hFFFF, digit_valid=0, frame_valid=0, err_pulse=0.
2. Single-digit capture: hold seg_input=1011011 and dig_sel=0001.
   - On edge 5, bin_output[3:0]=4'h2 and digit_valid=0001.
   - Holding for another 20 cycles causes no further capture and no frame_valid.
3. Glitch rejection: hold 1001111/0010 for 4 edges, then switch to 0000110/0010. Nibble 1 is never 3; it becomes 1 five edges after the switch.
4. Full frame: present 1, 9, 0, 7 on strobes 0001, 0010, 0100, 1000, each for 6 cycles, with 2 blank cycles (dig_sel=0) between digits.
   - Final state: bin_output=16'h7091, digit_valid=1111.
   - frame_valid pulses exactly once, on the digit-3 capture edge.
5. Error cases:
   - seg_input=1110000 on dig_sel=0010: nibble 1=F, digit_valid[1]=0, err_pulse for one cycle.
   - dig_sel=0011 held stable: err_pulse only, outputs unchanged.
   - dig_sel=0000: no err_pulse.
6. Mid-frame reset: capture digits 0 and 1, then pulse rst_n low for 1 cycle.
   - Outputs return to reset values.
   - Capturing digits 2 and 3 alone gives no frame_valid; all four digits are required.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns (bit0=a .. bit6=g) for digits 0-9 and the blank nibble, shared by encoder and decoder
package seven_seg_pkg;
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
endpackage

// File: rtl/seven_segment_pattern_decode.sv
// seven_segment_pattern_decode: combinational segment pattern to digit value
//   pattern : 7-bit segment pattern, bit0=a .. bit6=g
//   legal   : pattern is one of the ten digit encodings
//   value   : decoded digit, BLANK_NIBBLE when illegal
module seven_segment_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] value
);
    always_comb begin
        legal = 1'b1;
        value = BLANK_NIBBLE;
        case (pattern)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder: recovers digit values from a multiplexed 7-segment bus
//   clk, rst_n  : clock, asynchronous active-low reset
//   seg_input   : segment lines, bit0=a .. bit6=g
//   dig_sel     : one-hot digit strobe, bit i selects digit i
//   bin_output  : recovered digits, nibble i = digit i
//   digit_valid : nibble i holds a legal decoded value
//   frame_valid : pulse when every digit has been captured since the last pulse
//   err_pulse   : pulse on an illegal pattern or a multi-bit strobe
module seven_segment_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_input,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bin_output,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    err_pulse
);
    logic [6:0]            s_seg;
    logic [NUM_DIGITS-1:0] s_sel;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_DIGITS-1:0] seen;
    logic                  legal;
    logic [3:0]            value;

    // Capture fires once per stable window: the counter saturates past the capture point.
    wire match    = (seg_input == s_seg) && (dig_sel == s_sel);
    wire capture  = match && (cnt == CNT_W'(STABLE_CYCLES - 1));
    wire one_hot  = $onehot(s_sel);
    wire multi    = (|s_sel) && !one_hot;
    wire [NUM_DIGITS-1:0] seen_next = seen | s_sel;

    seven_segment_pattern_decode u_decode (
        .pattern (s_seg),
        .legal   (legal),
        .value   (value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg       <= '0;
            s_sel       <= '0;
            cnt         <= '0;
            seen        <= '0;
            bin_output  <= {NUM_DIGITS{BLANK_NIBBLE}};
            digit_valid <= '0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            if (!match) begin
                s_seg <= seg_input;
                s_sel <= dig_sel;
                cnt   <= '0;
            end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
                cnt <= cnt + CNT_W'(1);
            end
            err_pulse   <= capture && (multi || (one_hot && !legal));
            frame_valid <= capture && one_hot && (&seen_next);
            if (capture && one_hot) begin
                seen <= (&seen_next) ? '0 : seen_next;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (s_sel[i]) begin
                        bin_output[4*i +: 4] <= legal ? value : BLANK_NIBBLE;
                        digit_valid[i]       <= legal;
                    end
                end
            end
        end
    end
endmodule
